// File: rtl/riscv_wb_arbiter.sv
// Writeback-port arbiter for the RV64I register file: the pipeline writes first and is
// never stalled, and long-op results bypass or wait in an in-order buffer.
module riscv_wb_arbiter #(
   parameter int DEPTH = 2,
   parameter int CW    = $clog2(DEPTH+1)
) (
   input  logic          i_riscv_wbarb_clk,
   input  logic          i_riscv_rf_rst,
   input  logic          i_riscv_wbarb_pipe_regwrite,
   input  logic [4:0]    i_riscv_wbarb_pipe_rdaddr,
   input  logic [63:0]   i_riscv_wbarb_pipe_rddata,
   input  logic          i_riscv_wbarb_lop_valid,
   output logic          o_riscv_wbarb_lop_ready,
   input  logic [4:0]    i_riscv_wbarb_lop_rdaddr,
   input  logic [63:0]   i_riscv_wbarb_lop_rddata,
   output logic          o_riscv_wbarb_regwrite,
   output logic [4:0]    o_riscv_wbarb_rdaddr,
   output logic [63:0]   o_riscv_wbarb_rddata,
   output logic [31:0]   o_riscv_wbarb_pending,
   output logic [CW-1:0] o_riscv_wbarb_count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [4:0]       addr_reg [DEPTH];
   logic [63:0]      data_reg [DEPTH];
   logic [DEPTH-1:0] occ_reg, occ_next;
   logic [DEPTH-1:0] kill_reg, kill_next;
   logic [PTR_W-1:0] head_reg, head_next;
   logic [PTR_W-1:0] tail_reg, tail_next;
   logic [CW-1:0]    count_reg, count_next;

   logic pipe_wr, lop_hs, buf_empty, bypass, push, pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Ready looks only at registered occupancy, so it never depends on this cycle's inputs.
   assign o_riscv_wbarb_lop_ready = (count_reg < CW'(DEPTH));
   assign o_riscv_wbarb_count     = count_reg;

   assign pipe_wr   = i_riscv_wbarb_pipe_regwrite && (i_riscv_wbarb_pipe_rdaddr != 5'd0);
   assign lop_hs    = i_riscv_wbarb_lop_valid && o_riscv_wbarb_lop_ready;
   assign buf_empty = (count_reg == '0);
   assign bypass    = !pipe_wr && buf_empty && lop_hs && (i_riscv_wbarb_lop_rdaddr != 5'd0);
   // A result whose register the pipe overwrites in the same cycle is already stale.
   assign push      = lop_hs && (i_riscv_wbarb_lop_rdaddr != 5'd0) && !bypass &&
                      !(pipe_wr && (i_riscv_wbarb_pipe_rdaddr == i_riscv_wbarb_lop_rdaddr));
   assign pop       = !pipe_wr && !buf_empty;

   always_comb begin
      o_riscv_wbarb_regwrite = 1'b0;
      o_riscv_wbarb_rdaddr   = 5'd0;
      o_riscv_wbarb_rddata   = 64'd0;
      if (pipe_wr) begin
         o_riscv_wbarb_regwrite = 1'b1;
         o_riscv_wbarb_rdaddr   = i_riscv_wbarb_pipe_rdaddr;
         o_riscv_wbarb_rddata   = i_riscv_wbarb_pipe_rddata;
      end else if (!buf_empty) begin
         o_riscv_wbarb_regwrite = !kill_reg[head_reg];
         o_riscv_wbarb_rdaddr   = addr_reg[head_reg];
         o_riscv_wbarb_rddata   = data_reg[head_reg];
      end else if (bypass) begin
         o_riscv_wbarb_regwrite = 1'b1;
         o_riscv_wbarb_rdaddr   = i_riscv_wbarb_lop_rdaddr;
         o_riscv_wbarb_rddata   = i_riscv_wbarb_lop_rddata;
      end
   end

   always_comb begin
      occ_next   = occ_reg;
      kill_next  = kill_reg;
      head_next  = head_reg;
      tail_next  = tail_reg;
      count_next = count_reg;
      for (int i = 0; i < DEPTH; i++) begin
         // The pipe instruction is younger than any buffered long op, so it wins the WAW.
         if (pipe_wr && occ_reg[i] && (addr_reg[i] == i_riscv_wbarb_pipe_rdaddr))
            kill_next[i] = 1'b1;
         if (pop && (head_reg == PTR_W'(i)))
            occ_next[i] = 1'b0;
         if (push && (tail_reg == PTR_W'(i))) begin
            occ_next[i]  = 1'b1;
            kill_next[i] = 1'b0;
         end
      end
      if (pop)
         head_next = ptr_inc(head_reg);
      if (push)
         tail_next = ptr_inc(tail_reg);
      case ({push, pop})
         2'b10:   count_next = count_reg + CW'(1);
         2'b01:   count_next = count_reg - CW'(1);
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge i_riscv_wbarb_clk or posedge i_riscv_rf_rst) begin
      if (i_riscv_rf_rst) begin
         occ_reg   <= '0;
         kill_reg  <= '0;
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
      end else begin
         occ_reg   <= occ_next;
         kill_reg  <= kill_next;
         head_reg  <= head_next;
         tail_reg  <= tail_next;
         count_reg <= count_next;
      end
   end

   // Payload needs no reset: it is only read while the entry is occupied.
   always_ff @(posedge i_riscv_wbarb_clk) begin
      if (push) begin
         addr_reg[tail_reg] <= i_riscv_wbarb_lop_rdaddr;
         data_reg[tail_reg] <= i_riscv_wbarb_lop_rddata;
      end
   end

   logic [31:0] entry_mask [DEPTH];

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_pending
         assign entry_mask[gi] = (occ_reg[gi] && !kill_reg[gi]) ? (32'd1 << addr_reg[gi]) : 32'd0;
      end
   endgenerate

   always_comb begin
      o_riscv_wbarb_pending = 32'd0;
      for (int i = 0; i < DEPTH; i++)
         o_riscv_wbarb_pending = o_riscv_wbarb_pending | entry_mask[i];
      o_riscv_wbarb_pending[0] = 1'b0;
   end

endmodule

// File: doc/riscv_wb_arbiter.md
# riscv_wb_arbiter

Writeback-port arbiter that feeds the single write port of the RV64I register file (`regwrite`/`rdaddr`/`rddata`). It merges two writeback sources:
- the in-order pipeline writeback, which always has priority and is never stalled;
- results from long-latency units (mul/div), which use a valid/ready handshake and are parked in a small in-order buffer until the port is free.

It also kills buffered results made stale by a younger pipeline write to the same register (WAW), and exports a pending-register mask to the hazard unit.

## Interface
Parameters:
- DEPTH, 2, number of buffer entries for long-latency results (≥1)
- CW, $clog2(DEPTH+1), width of occupancy count

Ports:
- i_riscv_wbarb_clk  in  1  clock, rising-edge state update
- i_riscv_rf_rst  in  1  reset, asynchronous, active-high
- i_riscv_wbarb_pipe_regwrite  in  1  pipeline writeback enable
- i_riscv_wbarb_pipe_rdaddr  in  5  pipeline destination register
- i_riscv_wbarb_pipe_rddata  in  64  pipeline writeback data
- i_riscv_wbarb_lop_valid  in  1  long-op result valid
- o_riscv_wbarb_lop_ready  out  1  arbiter can accept long-op result
- i_riscv_wbarb_lop_rdaddr  in  5  long-op destination register
- i_riscv_wbarb_lop_rddata  in  64  long-op result data
- o_riscv_wbarb_regwrite  out  1  to register file write enable
- o_riscv_wbarb_rdaddr  out  5  to register file write address
- o_riscv_wbarb_rddata  out  64  to register file write data
- o_riscv_wbarb_pending  out  32  bit r set when live buffered entry targets xr; bit 0 always 0
- o_riscv_wbarb_count  out  CW  number of occupied buffer entries (live + killed)

## Operation
- Effective pipe write (PW): pipe_regwrite==1 && pipe_rdaddr!=0.
- Handshake (HS): lop_valid && lop_ready. lop_ready = (count < DEPTH). It depends on registered state only.
- Buffer: FIFO of {rdaddr, rddata, kill}. Entries are written to the RF strictly in arrival order.
- Output select (combinational, first match wins):
  1. PW: drive the pipe fields, regwrite=1.
  2. Buffer non-empty: drive the head entry. regwrite = !head.kill. The head is popped at the clock edge. A killed head takes one cycle with regwrite=0.
  3. Buffer empty && HS && lop_rdaddr!=0: bypass. Drive the lop fields, regwrite=1, nothing enqueued.
  4. Otherwise: regwrite=0. rdaddr/rddata are don't-care and are driven 0.
- Enqueue: HS && lop_rdaddr!=0 && not bypassed → push at the tail with kill=0.
  - Exception: if PW && pipe_rdaddr==lop_rdaddr, the result is accepted (handshake completes) but not enqueued.
  - HS with lop_rdaddr==0: accepted and discarded.
- Kill: on PW with rd==X, every buffered entry with rdaddr==X has kill set at that edge. Rationale: the pipe instruction is younger than any outstanding long op.
- Push and pop in the same cycle are legal. Count changes by push − pop.
- pending: OR of one-hot(rdaddr) over occupied entries with kill==0. Bit 0 is forced 0.

## Timing
- Reset (async assert, registered state only): count=0, all entries empty, kill bits 0.
- Outputs during and after reset:
  - pending=0 and lop_ready=1.
  - o_riscv_wbarb_regwrite/rdaddr/rddata remain combinational: they follow the pipe inputs under PW, otherwise regwrite=0 and rdaddr/rddata=0. The lop bypass path is also live, since lop_ready=1.
- Reset mid-operation discards all buffered results without writing them.
- Latency:
  - pipe → RF port: 0 cycles (combinational).
  - lop bypass: 0 cycles.
  - Buffered entry: written in the first cycle it is head with no PW.
- The RF samples the write port on the falling edge of its clock (`i_riscv_rf_clk_n`). The outputs must be settled by mid-cycle: select logic only, no deep paths.
- Full: lop_ready=0. A lop_valid held high must keep its data stable until HS.
- Buffer full and PW every cycle: the buffer does not drain, and lop_ready stays 0 until a non-PW cycle.
- Pointer wrap: modulo DEPTH. count distinguishes full from empty.

## Test plan
- Reset, then pipe write x5=0x1234 with lop idle → regwrite=1, rdaddr=5, rddata=0x1234 in the same cycle; count=0.
- Lop x7=0xAA, buffer empty, no PW → bypass write of x7=0xAA in the same cycle; count stays 0; pending=0.
- Lop x7=0xAA during PW x3 → x3 written; count=1 and pending[7]=1 next cycle; next idle cycle writes x7=0xAA; count=0 and pending=0 after.
- Buffer holds x9 (count=1); PW x9=0x55 → x9=0x55 written; entry killed and pending[9]=0; next idle cycle drains with regwrite=0; RF x9 stays 0x55.
- Four consecutive PW cycles with lop_valid held and DEPTH=2 → two results accepted; lop_ready=0 while count=2; two idle cycles drain in order; then lop_ready=1.
- Assert i_riscv_rf_rst with count=2 → count=0, pending=0 and lop_ready=1 immediately; regwrite=0 with no PW and lop_valid=0; no buffered entry is written after release.
